ahb_arbiter: RTL



---
 rtl/ahb_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/ahb_arbiter.sv
// Round-robin AHB arbiter: keeps fixed-length bursts and locked sequences intact,
// changes ownership only on hready edges.
module ahb_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                   hclk,
  input  logic                   hreset,
  input  logic [NUM_MASTERS-1:0] hbusreq,
  input  logic [NUM_MASTERS-1:0] hlock,
  input  logic [1:0]             htrans,
  input  logic [2:0]             hburst,
  input  logic                   hready,
  input  logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hgrant,
  output logic [3:0]             hmaster,
  output logic                   hmastlock
);

  localparam logic [3:0]             DEF_IDX   = 4'(DEFAULT_MASTER);
  localparam logic [NUM_MASTERS-1:0] DEF_GRANT = NUM_MASTERS'(1) << DEFAULT_MASTER;

  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic [3:0] beats_left, beats_left_next;
  logic [3:0] last, g, winner;
  logic       lock_g, found, hold;

  // Decode the current grant holder and its lock request.
  always_comb begin
    g      = DEF_IDX;
    lock_g = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (hgrant[i]) begin
        g      = 4'(i);
        lock_g = hlock[i];
      end
    end
  end

  always_comb begin
    beats_left_next = beats_left;
    case (htrans)
      T_NONSEQ: begin
        case (hburst)
          3'b010, 3'b011: beats_left_next = 4'd3;
          3'b100, 3'b101: beats_left_next = 4'd7;
          3'b110, 3'b111: beats_left_next = 4'd15;
          default:        beats_left_next = 4'd0;
        endcase
      end
      T_SEQ:   if (beats_left != 4'd0) beats_left_next = beats_left - 4'd1;
      default: beats_left_next = beats_left;
    endcase
  end

  assign hold = (beats_left_next != 4'd0) || lock_g;

  // Round-robin: search last+1..N-1 first, then wrap to 0..last.
  always_comb begin
    found  = 1'b0;
    winner = last;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && hbusreq[j] && (4'(j) > last)) begin
        found  = 1'b1;
        winner = 4'(j);
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && hbusreq[j] && (4'(j) <= last)) begin
        found  = 1'b1;
        winner = 4'(j);
      end
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hgrant     <= DEF_GRANT;
      hmaster    <= DEF_IDX;
      hmastlock  <= 1'b0;
      beats_left <= 4'd0;
      last       <= DEF_IDX;
    end else if (hready) begin
      hmaster    <= g;
      hmastlock  <= lock_g;
      beats_left <= beats_left_next;
      if (!hold) begin
        if (found) begin
          hgrant <= NUM_MASTERS'(1) << winner;
          last   <= winner;
        end else begin
          hgrant <= DEF_GRANT;
        end
      end
    end else if (hresp != 2'b00) begin
      // First cycle of an ERROR/RETRY/SPLIT: drop the burst so the next edge can re-arbitrate.
      beats_left <= 4'd0;
    end
  end

endmodule
